mips_fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the processor datapath.
- Owns the architectural PC and issues word fetches to instruction memory over a req/gnt/rvalid bus.
- Holds one fetched instruction plus its PC in an output buffer and hands it to decode/execute with a valid/ready handshake.
- Accepts redirects (branch/jump target already computed downstream), discarding any in-flight wrong-path fetch.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_fetch_buf.sv | 34 +++
 rtl/mips_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_mips_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int unsigned       WORD_W           = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mips_fetch_buf.sv
// Single-entry instruction buffer with valid/ready pop and flush.
module mips_fetch_buf
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [WORD_W-1:0] wr_instr,
  input  logic [WORD_W-1:0] wr_pc,
  input  logic              pop,
  input  logic              flush,
  output logic              valid,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc
);

  // Flush wins over a concurrent write; the entry holds while not popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      instruction <= '0;
      pc          <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (write) begin
      valid       <= 1'b1;
      instruction <= wr_instr;
      pc          <= wr_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a
// time and delivers instructions through a one-entry valid/ready buffer.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] ins_pc,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] gnt_addr_q, gnt_addr_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;
  logic              req_q;
  logic              buf_write, buf_flush, buf_pop;
  logic              redir_ok, redir_bad;

  assign buf_pop   = ins_valid && ins_ready;
  assign redir_ok  = redirect_valid && is_word_aligned(redirect_pc);
  assign redir_bad = redirect_valid && !is_word_aligned(redirect_pc);
  assign buf_flush = redirect_valid && (state_q != S_HALT);

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign fetch_err = err_q;

  // Fetch state register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      gnt_addr_q <= '0;
      wait_cnt_q <= '0;
      discard_q  <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      gnt_addr_q <= gnt_addr_d;
      wait_cnt_q <= wait_cnt_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
      req_q      <= (state_d == S_REQ);
    end
  end

  // Next-state, PC update, discard tracking and buffer write control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    gnt_addr_d = gnt_addr_q;
    wait_cnt_d = wait_cnt_q;
    discard_d  = discard_q;
    err_d      = err_q;
    buf_write  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (redir_ok) begin
          pc_d = redirect_pc;
        end else if (!ins_valid || ins_ready) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          gnt_addr_d = addr_q;
          if (!discard_q) pc_d = pc_q + WORD_W'(4);
        end
        if (redir_ok) begin
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          buf_write = !discard_q && !redirect_valid;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if (redir_ok) begin
          pc_d      = redirect_pc;
          discard_d = !imem_rvalid;
        end
      end
      S_HALT: begin
      end
    endcase

    // A misaligned target is fatal; any in-flight response is ignored in halt.
    if (redir_bad && (state_q != S_HALT)) begin
      state_d   = S_HALT;
      err_d     = 1'b1;
      buf_write = 1'b0;
    end

    // The bus address is frozen while a request waits for its grant.
    if (!(state_q == S_REQ && !imem_gnt)) addr_d = pc_d;
  end

  mips_fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .write      (buf_write),
    .wr_instr   (imem_rdata),
    .wr_pc      (gnt_addr_q),
    .pop        (buf_pop),
    .flush      (buf_flush),
    .valid      (ins_valid),
    .instruction(instruction),
    .pc         (ins_pc)
  );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a PC-stream reference model.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] instruction;
  logic [31:0] ins_pc;
  logic        fetch_err;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .instruction   (instruction),
    .ins_pc        (ins_pc),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_000A;
    return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
  endfunction

  // Stimulus knobs
  int unsigned gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;
  bit          mem_mute = 0;
  bit          redir_pending = 0;
  logic [31:0] redir_target = '0;
  bit          gr_armed = 0;
  logic [31:0] gr_addr = '0, gr_target = '0;

  // Memory model and observation state
  bit          outstanding = 0;
  int          rv_cnt = 0;
  logic [31:0] out_addr = '0;
  bit          gnt_seen = 0, pop_seen = 0, saw_14 = 0;
  logic [31:0] last_gnt = '0, last_pop_pc = '0, last_pop_ins = '0;
  int          gnt_cnt = 0, cyc = 0, n_pops = 0;
  int          pop_cyc[$];

  // Reference model: expected PC of the next delivered instruction
  logic [31:0] exp_pc = '0;
  bit          prev_redir = 0, prev_bad = 0, prev_stall = 0, prev_req_wait = 0;
  logic [31:0] prev_pc = '0, prev_ins = '0, prev_addr = '0;

  task automatic cycle();
    bit pop;
    @(negedge clk);
    cyc++;
    if (prev_redir) begin
      check("flush_after_redirect", 32'(ins_valid), 32'd0);
    end else if (prev_stall) begin
      check("hold_valid", 32'(ins_valid), 32'd1);
      check("hold_pc", ins_pc, prev_pc);
      check("hold_ins", instruction, prev_ins);
    end
    if (prev_req_wait) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, prev_addr);
    end
    if (imem_req) begin
      check("one_outstanding", 32'(outstanding), 32'd0);
      check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      if (imem_addr == 32'h14) saw_14 = 1;
    end

    ins_ready      = ($urandom_range(99) < ready_pct);
    redirect_valid = redir_pending;
    redirect_pc    = redir_target;
    redir_pending  = 0;
    imem_gnt       = imem_req && ($urandom_range(99) < gnt_pct);
    if (gr_armed && imem_req && imem_addr == gr_addr) begin
      imem_gnt       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = gr_target;
      gr_armed       = 0;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (outstanding && !mem_mute) begin
      if (rv_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(out_addr);
        outstanding = 0;
      end else begin
        rv_cnt--;
      end
    end
    if (imem_gnt) begin
      outstanding = 1;
      out_addr    = imem_addr;
      rv_cnt      = int'($urandom_range(lat_max, lat_min)) - 1;
      gnt_seen    = 1;
      last_gnt    = imem_addr;
      gnt_cnt++;
    end

    pop = ins_valid && ins_ready;
    if (pop) begin
      check("ins_pc", ins_pc, exp_pc);
      check("instruction", instruction, mem_word(exp_pc));
      pop_seen     = 1;
      last_pop_pc  = ins_pc;
      last_pop_ins = instruction;
      pop_cyc.push_back(cyc);
      n_pops++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid && redirect_pc[1:0] == 2'b00) exp_pc = redirect_pc;

    prev_redir    = redirect_valid;
    prev_bad      = redirect_valid && redirect_pc[1:0] != 2'b00;
    prev_stall    = ins_valid && !ins_ready && !redirect_valid;
    prev_pc       = ins_pc;
    prev_ins      = instruction;
    prev_req_wait = imem_req && !imem_gnt && !prev_bad;
    prev_addr     = imem_addr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ins_ready      = 1'b0;
    outstanding    = 0;
    mem_mute       = 0;
    redir_pending  = 0;
    gr_armed       = 0;
    exp_pc         = 32'h0;
    prev_redir = 0; prev_bad = 0; prev_stall = 0; prev_req_wait = 0;
    gnt_cnt = 0;
    saw_14  = 0;
    pop_cyc.delete();
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_ins", instruction, 32'h0);
    check("rst_pc", ins_pc, 32'h0);
    check("rst_err", 32'(fetch_err), 32'd0);
    reset = 1'b1;
  endtask

  task automatic run_until_gnt(input string tag, input logic [31:0] exp_addr);
    gnt_seen = 0;
    for (int i = 0; i < 400 && !gnt_seen; i++) cycle();
    check({tag, "_seen"}, 32'(gnt_seen), 32'd1);
    check(tag, last_gnt, exp_addr);
  endtask

  task automatic run_until_pop(input string tag, input logic [31:0] exp_pc_v);
    pop_seen = 0;
    for (int i = 0; i < 400 && !pop_seen; i++) cycle();
    check({tag, "_seen"}, 32'(pop_seen), 32'd1);
    check(tag, last_pop_pc, exp_pc_v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rand_pops;
    reset = 1'b0;

    // Back-to-back delivery with a 1-cycle memory
    do_reset();
    run_until_pop("t1_pop0", 32'h0);
    check("t1_ins0", last_pop_ins, 32'h2008_0005);
    run_until_pop("t1_pop1", 32'h4);
    check("t1_ins1", last_pop_ins, 32'h2009_000A);
    check("t1_rate", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);

    // Consumer stall: one request only, no further requests until a pop
    do_reset();
    ready_pct = 0;
    for (int i = 0; i < 20 && !ins_valid; i++) cycle();
    check("t2_valid", 32'(ins_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t2_no_req", 32'(imem_req), 32'd0);
    end
    check("t2_gnt_count", 32'(gnt_cnt), 32'd1);
    ready_pct = 100;
    run_until_pop("t2_pop", 32'h0);

    // Redirect while waiting for the 0x8 response
    do_reset();
    lat_min = 3; lat_max = 3;
    run_until_gnt("t3_g0", 32'h0);
    run_until_gnt("t3_g4", 32'h4);
    run_until_gnt("t3_g8", 32'h8);
    redir_pending = 1; redir_target = 32'h100;
    cycle();
    run_until_gnt("t3_g100", 32'h100);
    run_until_pop("t3_pop100", 32'h100);

    // Redirect coinciding with the grant for 0x10
    do_reset();
    lat_min = 1; lat_max = 1;
    gr_armed = 1; gr_addr = 32'h10; gr_target = 32'h40;
    for (int i = 0; i < 5; i++) run_until_gnt("t4_seq", 32'(i * 4));
    run_until_gnt("t4_g40", 32'h40);
    run_until_pop("t4_pop40", 32'h40);
    check("t4_no_0x14", 32'(saw_14), 32'd0);

    // Misaligned redirect halts the unit until reset
    redir_pending = 1; redir_target = 32'h102;
    cycle();
    cycle();
    check("t5_err", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 22; i++) begin
      cycle();
      check("t5_no_req", 32'(imem_req), 32'd0);
    end
    check("t5_err_sticky", 32'(fetch_err), 32'd1);
    do_reset();
    run_until_gnt("t5_restart", 32'h0);

    // Redirect to the top word while a request waits; PC wraps to 0
    do_reset();
    gnt_pct = 0;
    cycle();
    redir_pending = 1; redir_target = 32'hFFFF_FFFC;
    cycle();
    cycle();
    check("t6_addr_stable", imem_addr, 32'h0);
    gnt_pct = 100;
    run_until_gnt("t6_g0_dropped", 32'h0);
    run_until_gnt("t6_gtop", 32'hFFFF_FFFC);
    run_until_pop("t6_poptop", 32'hFFFF_FFFC);
    run_until_gnt("t6_gwrap", 32'h0);
    run_until_pop("t6_popwrap", 32'h0);

    // Reset in the middle of a wait, then a late response
    lat_min = 4; lat_max = 4;
    run_until_gnt("t7_g4", 32'h4);
    cycle();
    do_reset();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    gnt_pct = 0; ready_pct = 100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t7_no_valid", 32'(ins_valid), 32'd0);
    end
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    run_until_pop("t7_pop0", 32'h0);

    // Bus timeout
    do_reset();
    mem_mute = 1;
    run_until_gnt("t8_g0", 32'h0);
    for (int i = 0; i < 250; i++) cycle();
    check("t8_no_err_yet", 32'(fetch_err), 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    check("t8_timeout", 32'(fetch_err), 32'd1);

    // Random traffic with random redirects
    do_reset();
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 3;
    n_pops = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 3) begin
        redir_pending = 1;
        redir_target  = 32'($urandom_range(1023)) << 2;
      end
      cycle();
    end
    rand_pops = n_pops;
    check("rand_progress", 32'(rand_pops > 100), 32'd1);
    check("rand_no_err", 32'(fetch_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
